// File: rtl/multi_type_task_fifo.sv
// ---------------------------------------------------------------------------
// multi_type_task_fifo
//
// Holds one circular queue per task type between the task queue and the
// conflict checker. Whenever no task is outstanding, the block picks the
// queue whose head carries the lowest timestamp. Ties go to the first type
// at or after a round-robin pointer. That head is offered to the conflict
// checker until it answers. An accepted task is popped. A rejected task is
// rotated to the tail of its own queue.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     enqueue handshake; in_ready is combinational on in_type
//   in_type/in_data/in_slot  target queue, payload (timestamp in low TS_W bits), cq slot
//   out_valid/out_type/out_data/out_slot  task offered to the conflict checker
//   resp_valid/resp_reject   conflict-check answer (0 accept, 1 reject)
//   cfg_wvalid/cfg_type/cfg_thresh  per-type full threshold write (clamped 1..DEPTH)
//   occupancy             per-type entry counts, type k at slice k
//   reject_cnt            per-type saturating reject counters
//   fifo_empty            all queues empty and no offer outstanding
//   lvt                   lowest head timestamp, all-ones when every queue is empty
// ---------------------------------------------------------------------------
module multi_type_task_fifo #(
    parameter int N_TYPES        = 4,
    parameter int TYPE_W         = 2,
    parameter int LOG_DEPTH      = 6,
    parameter int DATA_W         = 128,
    parameter int TS_W           = 32,
    parameter int SLOT_W         = 8,
    parameter int DEFAULT_THRESH = 2,
    parameter int CNT_W          = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [TYPE_W-1:0]                in_type,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [SLOT_W-1:0]                in_slot,
    output logic                             out_valid,
    output logic [TYPE_W-1:0]                out_type,
    output logic [DATA_W-1:0]                out_data,
    output logic [SLOT_W-1:0]                out_slot,
    input  logic                             resp_valid,
    input  logic                             resp_reject,
    input  logic                             cfg_wvalid,
    input  logic [TYPE_W-1:0]                cfg_type,
    input  logic [LOG_DEPTH:0]               cfg_thresh,
    output logic [N_TYPES*(LOG_DEPTH+1)-1:0] occupancy,
    output logic [N_TYPES*CNT_W-1:0]         reject_cnt,
    output logic                             fifo_empty,
    output logic [TS_W-1:0]                  lvt
);

    localparam int DEPTH   = 2 ** LOG_DEPTH;
    localparam int OCC_W   = LOG_DEPTH + 1;
    localparam int ENTRY_W = SLOT_W + DATA_W;
    localparam int THRESH_CLAMPED = (DEFAULT_THRESH < 1) ? 1 :
                                    (DEFAULT_THRESH > DEPTH) ? DEPTH : DEFAULT_THRESH;
    localparam logic [OCC_W-1:0] THRESH_RST = OCC_W'(THRESH_CLAMPED);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    // Entries are stored as {slot, payload}.
    logic [ENTRY_W-1:0]   mem     [N_TYPES][DEPTH];
    logic [LOG_DEPTH-1:0] rd_ptr  [N_TYPES];
    logic [LOG_DEPTH-1:0] wr_ptr  [N_TYPES];
    logic [OCC_W-1:0]     count   [N_TYPES];
    logic [OCC_W-1:0]     thresh  [N_TYPES];
    logic [CNT_W-1:0]     rej_cnt [N_TYPES];
    logic [ENTRY_W-1:0]   head    [N_TYPES];

    logic [N_TYPES-1:0] full;
    logic [N_TYPES-1:0] nonempty;
    logic [N_TYPES-1:0] pop;
    logic [N_TYPES-1:0] push;
    logic [N_TYPES-1:0] rotate;

    state_t            state, state_next;
    logic [TYPE_W-1:0] sel, sel_next;
    logic [TYPE_W-1:0] rr, rr_next;

    logic              best_found;
    logic [TYPE_W-1:0] best_type;
    logic [TS_W-1:0]   best_ts;

    logic              type_ok;
    logic              type_full;
    logic              enq_fire;
    logic              resp_fire;
    logic [OCC_W-1:0]  cfg_clamped;

    assign resp_fire = (state == OFFER) && resp_valid;
    assign enq_fire  = in_valid && in_ready;

    // Per-type head, empty and full status.
    always_comb begin
        for (int k = 0; k < N_TYPES; k++) begin
            head[k]     = mem[k][rd_ptr[k]];
            nonempty[k] = (count[k] != '0);
            full[k]     = (count[k] >= thresh[k]);
        end
    end

    // Enqueue acceptance. Out-of-range types never match the loop, so they
    // are refused. The queue being rotated this cycle already uses its one
    // write port for the rejected entry, so it refuses new work.
    always_comb begin
        type_ok   = 1'b0;
        type_full = 1'b0;
        for (int k = 0; k < N_TYPES; k++) begin
            if (in_type == TYPE_W'(k)) begin
                type_ok   = 1'b1;
                type_full = full[k];
            end
        end
        in_ready = !rst && type_ok && !type_full &&
                   !(resp_fire && resp_reject && (sel == in_type));
    end

    // Per-type push/pop strobes. A reject pops and pushes the same queue,
    // which moves the head entry to the tail.
    always_comb begin
        for (int k = 0; k < N_TYPES; k++) begin
            pop[k]    = resp_fire && (sel == TYPE_W'(k));
            rotate[k] = pop[k] && resp_reject;
            push[k]   = rotate[k] || (enq_fire && (in_type == TYPE_W'(k)));
        end
    end

    // Threshold writes are clamped into the legal 1..DEPTH range.
    always_comb begin
        cfg_clamped = cfg_thresh;
        if (cfg_thresh == '0) begin
            cfg_clamped = OCC_W'(1);
        end else if (cfg_thresh > OCC_W'(DEPTH)) begin
            cfg_clamped = OCC_W'(DEPTH);
        end
    end

    // Queue storage. It has no reset because the pointers define which
    // entries are live.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_TYPES; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= rotate[k] ? head[k] : {in_slot, in_data};
            end
        end
    end

    // Pointers, occupancy, thresholds and reject counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_TYPES; k++) begin
                rd_ptr[k]  <= '0;
                wr_ptr[k]  <= '0;
                count[k]   <= '0;
                thresh[k]  <= THRESH_RST;
                rej_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_TYPES; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + LOG_DEPTH'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + LOG_DEPTH'(1);
                end
                if (push[k] && !pop[k]) begin
                    count[k] <= count[k] + OCC_W'(1);
                end else if (pop[k] && !push[k]) begin
                    count[k] <= count[k] - OCC_W'(1);
                end
                if (rotate[k] && (rej_cnt[k] != '1)) begin
                    rej_cnt[k] <= rej_cnt[k] + CNT_W'(1);
                end
                if (cfg_wvalid && (cfg_type == TYPE_W'(k))) begin
                    thresh[k] <= cfg_clamped;
                end
            end
        end
    end

    // Lowest-timestamp search. The scan starts at the round-robin pointer
    // and uses a strict less-than, so the first type at or after rr wins a tie.
    always_comb begin
        int idx;
        best_found = 1'b0;
        best_type  = '0;
        best_ts    = '1;
        for (int i = 0; i < N_TYPES; i++) begin
            idx = int'(rr) + i;
            if (idx >= N_TYPES) begin
                idx = idx - N_TYPES;
            end
            if (nonempty[idx] && (!best_found || (head[idx][TS_W-1:0] < best_ts))) begin
                best_found = 1'b1;
                best_type  = TYPE_W'(idx);
                best_ts    = head[idx][TS_W-1:0];
            end
        end
    end

    // FSM state, selected type and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            rr    <= '0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
            rr    <= rr_next;
        end
    end

    // Next-state logic. A response always returns the FSM to IDLE. This
    // gives one bubble before the next selection is offered.
    always_comb begin
        state_next = state;
        sel_next   = sel;
        rr_next    = rr;
        case (state)
            IDLE: begin
                if (best_found) begin
                    sel_next   = best_type;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (resp_valid) begin
                    state_next = IDLE;
                    if (int'(sel) == N_TYPES - 1) begin
                        rr_next = '0;
                    end else begin
                        rr_next = sel + TYPE_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_valid  = (state == OFFER);
    assign out_type   = sel;
    assign out_data   = head[sel][DATA_W-1:0];
    assign out_slot   = head[sel][ENTRY_W-1:DATA_W];
    assign lvt        = best_ts;
    assign fifo_empty = (nonempty == '0) && (state == IDLE);

    for (genvar g = 0; g < N_TYPES; g++) begin : g_pack
        assign occupancy[g*OCC_W +: OCC_W]  = count[g];
        assign reject_cnt[g*CNT_W +: CNT_W] = rej_cnt[g];
    end

endmodule

// File: tb/tb_multi_type_task_fifo.sv
// ---------------------------------------------------------------------------
// tb_multi_type_task_fifo
//
// Scenario-driven bench for multi_type_task_fifo. Expected offers are queued
// in the order the design should present them. Each offer is popped and
// compared as the DUT raises out_valid.
// ---------------------------------------------------------------------------
module tb_multi_type_task_fifo;

    localparam int N_TYPES   = 4;
    localparam int TYPE_W    = 2;
    localparam int LOG_DEPTH = 6;
    localparam int DATA_W    = 128;
    localparam int TS_W      = 32;
    localparam int SLOT_W    = 8;
    localparam int CNT_W     = 16;
    localparam int OW        = LOG_DEPTH + 1;
    localparam int DEPTH     = 64;

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [TYPE_W-1:0]         in_type;
    logic [DATA_W-1:0]         in_data;
    logic [SLOT_W-1:0]         in_slot;
    logic                      out_valid;
    logic [TYPE_W-1:0]         out_type;
    logic [DATA_W-1:0]         out_data;
    logic [SLOT_W-1:0]         out_slot;
    logic                      resp_valid;
    logic                      resp_reject;
    logic                      cfg_wvalid;
    logic [TYPE_W-1:0]         cfg_type;
    logic [LOG_DEPTH:0]        cfg_thresh;
    logic [N_TYPES*OW-1:0]     occupancy;
    logic [N_TYPES*CNT_W-1:0]  reject_cnt;
    logic                      fifo_empty;
    logic [TS_W-1:0]           lvt;

    typedef struct {
        logic [TYPE_W-1:0] typ;
        logic [DATA_W-1:0] data;
        logic [SLOT_W-1:0] slot;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    multi_type_task_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_data    (in_data),
        .in_slot    (in_slot),
        .out_valid  (out_valid),
        .out_type   (out_type),
        .out_data   (out_data),
        .out_slot   (out_slot),
        .resp_valid (resp_valid),
        .resp_reject(resp_reject),
        .cfg_wvalid (cfg_wvalid),
        .cfg_type   (cfg_type),
        .cfg_thresh (cfg_thresh),
        .occupancy  (occupancy),
        .reject_cnt (reject_cnt),
        .fifo_empty (fifo_empty),
        .lvt        (lvt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DATA_W-1:0] make_data(input int t, input logic [31:0] ts);
        return {32'hC0DE_0000 + 32'(t), ts ^ 32'h5A5A_5A5A, 32'h1234_5678, ts};
    endfunction

    function automatic logic [OW-1:0] occ_of(input int k);
        return occupancy[k*OW +: OW];
    endfunction

    function automatic logic [CNT_W-1:0] rej_of(input int k);
        return reject_cnt[k*CNT_W +: CNT_W];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid    = 1'b0;
        in_type     = '0;
        in_data     = '0;
        in_slot     = '0;
        resp_valid  = 1'b0;
        resp_reject = 1'b0;
        cfg_wvalid  = 1'b0;
        cfg_type    = '0;
        cfg_thresh  = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic sb_push(input int t, input logic [31:0] ts, input logic [SLOT_W-1:0] slot);
        exp_t e;
        e.typ  = TYPE_W'(t);
        e.data = make_data(t, ts);
        e.slot = slot;
        sb.push_back(e);
    endtask

    // Presents one enqueue for a single cycle and checks the handshake.
    task automatic enqueue(input int t, input logic [31:0] ts, input logic [SLOT_W-1:0] slot,
                           input logic exp_ready, input string name);
        in_valid = 1'b1;
        in_type  = TYPE_W'(t);
        in_data  = make_data(t, ts);
        in_slot  = slot;
        #1;
        vectors++;
        if (in_ready !== exp_ready) begin
            miscompares++;
            $display("[TB] FAIL %s: in_ready=%b expected %b", name, in_ready, exp_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_offer(input string name);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s timeout: out_valid=%b expected 1 within 20 cycles", name, out_valid);
        end
    endtask

    // Waits for an offer, compares it with the scoreboard head and answers it.
    task automatic serve_one(input logic reject, input string name);
        exp_t e;
        wait_offer(name);
        if (out_valid !== 1'b1) return;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL %s unexpected offer: type=%0d ts=%0d, expected none",
                     name, out_type, out_data[31:0]);
        end else begin
            e = sb.pop_front();
            if (out_type !== e.typ || out_data !== e.data || out_slot !== e.slot) begin
                miscompares++;
                $display("[TB] FAIL %s offer: got type=%0d ts=%0d slot=%0h, expected type=%0d ts=%0d slot=%0h",
                         name, out_type, out_data[31:0], out_slot, e.typ, e.data[31:0], e.slot);
            end
        end
        resp_valid  = 1'b1;
        resp_reject = reject;
        tick();
        resp_valid  = 1'b0;
        resp_reject = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s bubble: out_valid=%b expected 0", name, out_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready_held: in_ready=%b expected 0", in_ready);
        end
        rst = 1'b0;
        sb.delete();
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready_released: in_ready=%b expected 1", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0 || fifo_empty !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: out_valid=%b fifo_empty=%b expected 0 1", out_valid, fifo_empty);
        end
        vectors++;
        if (lvt !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL reset_lvt: lvt=%h expected ffffffff", lvt);
        end
        vectors++;
        if (occupancy !== '0 || reject_cnt !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_counts: occupancy=%h reject_cnt=%h expected 0 0", occupancy, reject_cnt);
        end
        tick();
    endtask

    task automatic test_latency;
        do_reset();
        enqueue(1, 32'd50, 8'h51, 1'b1, "lat_enq");
        sb_push(1, 32'd50, 8'h51);
        vectors++;
        if (occ_of(1) !== OW'(1) || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lat_cycle1: occupancy1=%0d out_valid=%b expected 1 0", occ_of(1), out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_type !== 2'd1 || out_data[31:0] !== 32'd50) begin
            miscompares++;
            $display("[TB] FAIL lat_cycle2: out_valid=%b type=%0d ts=%0d expected 1 1 50",
                     out_valid, out_type, out_data[31:0]);
        end
        vectors++;
        if (lvt !== 32'd50 || fifo_empty !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lat_lvt: lvt=%0d fifo_empty=%b expected 50 0", lvt, fifo_empty);
        end
        serve_one(1'b0, "lat_serve");
        vectors++;
        if (fifo_empty !== 1'b1 || lvt !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL lat_drained: fifo_empty=%b lvt=%h expected 1 ffffffff", fifo_empty, lvt);
        end
    endtask

    // Type1 is offered first and stays outstanding while three equal
    // timestamps arrive. Its accept moves rr to 2, so the rotation then
    // runs 2, 3, 0.
    task automatic test_priority;
        do_reset();
        enqueue(1, 32'd100, 8'h01, 1'b1, "prio_enq1");
        enqueue(3, 32'd20, 8'h03, 1'b1, "prio_enq3");
        enqueue(0, 32'd20, 8'h00, 1'b1, "prio_enq0");
        enqueue(2, 32'd20, 8'h02, 1'b1, "prio_enq2");
        vectors++;
        if (lvt !== 32'd20) begin
            miscompares++;
            $display("[TB] FAIL prio_lvt: lvt=%0d expected 20", lvt);
        end
        sb_push(1, 32'd100, 8'h01);
        sb_push(2, 32'd20, 8'h02);
        sb_push(3, 32'd20, 8'h03);
        sb_push(0, 32'd20, 8'h00);
        for (int i = 0; i < 4; i++) serve_one(1'b0, "prio_serve");
    endtask

    task automatic test_reject;
        do_reset();
        enqueue(0, 32'd5, 8'hAA, 1'b1, "rej_enqA");
        enqueue(0, 32'd9, 8'hBB, 1'b1, "rej_enqB");
        sb_push(0, 32'd5, 8'hAA);
        serve_one(1'b1, "rej_first");
        vectors++;
        if (rej_of(0) !== CNT_W'(1) || occ_of(0) !== OW'(2)) begin
            miscompares++;
            $display("[TB] FAIL rej_counts: reject_cnt0=%0d occupancy0=%0d expected 1 2", rej_of(0), occ_of(0));
        end
        vectors++;
        if (lvt !== 32'd9) begin
            miscompares++;
            $display("[TB] FAIL rej_lvt: lvt=%0d expected 9", lvt);
        end
        sb_push(0, 32'd9, 8'hBB);
        sb_push(0, 32'd5, 8'hAA);
        serve_one(1'b0, "rej_B");
        serve_one(1'b0, "rej_A");
        vectors++;
        if (occ_of(0) !== '0 || rej_of(0) !== CNT_W'(1)) begin
            miscompares++;
            $display("[TB] FAIL rej_final: occupancy0=%0d reject_cnt0=%0d expected 0 1", occ_of(0), rej_of(0));
        end
    endtask

    task automatic test_threshold;
        do_reset();
        enqueue(0, 32'd200, 8'h00, 1'b1, "thr_enq0");
        enqueue(0, 32'd201, 8'h01, 1'b1, "thr_enq1");
        // A threshold write in the same cycle does not help this enqueue.
        in_valid   = 1'b1;
        in_type    = 2'd0;
        in_data    = make_data(0, 32'd202);
        in_slot    = 8'h02;
        cfg_wvalid = 1'b1;
        cfg_type   = 2'd0;
        cfg_thresh = 7'd64;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL thr_old_thresh: in_ready=%b expected 0", in_ready);
        end
        tick();
        in_valid   = 1'b0;
        cfg_wvalid = 1'b0;
        for (int i = 2; i < DEPTH; i++) begin
            enqueue(0, 32'(200 + i), 8'(i), 1'b1, "thr_fill");
        end
        vectors++;
        if (occ_of(0) !== OW'(64)) begin
            miscompares++;
            $display("[TB] FAIL thr_occ64: occupancy0=%0d expected 64", occ_of(0));
        end
        enqueue(0, 32'd999, 8'hFF, 1'b0, "thr_full64");
        cfg_wvalid = 1'b1;
        cfg_type   = 2'd0;
        cfg_thresh = 7'd0;
        tick();
        cfg_wvalid = 1'b0;
        vectors++;
        if (occ_of(0) !== OW'(64)) begin
            miscompares++;
            $display("[TB] FAIL thr_no_drop: occupancy0=%0d expected 64", occ_of(0));
        end
        for (int i = 0; i < DEPTH; i++) sb_push(0, 32'(200 + i), 8'(i));
        for (int i = 0; i < DEPTH; i++) serve_one(1'b0, "thr_drain");
        enqueue(0, 32'd300, 8'h30, 1'b1, "thr_clamp_first");
        enqueue(0, 32'd301, 8'h31, 1'b0, "thr_clamp_second");
    endtask

    task automatic test_collision;
        do_reset();
        enqueue(0, 32'd7, 8'h77, 1'b1, "col_enqX");
        wait_offer("col_offer");
        resp_valid  = 1'b1;
        resp_reject = 1'b1;
        in_valid    = 1'b1;
        in_type     = 2'd0;
        in_data     = make_data(1, 32'd3);
        in_slot     = 8'h33;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL col_same_type: in_ready=%b expected 0", in_ready);
        end
        in_type = 2'd1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL col_other_type: in_ready=%b expected 1", in_ready);
        end
        tick();
        idle_inputs();
        vectors++;
        if (rej_of(0) !== CNT_W'(1) || occ_of(0) !== OW'(1) || occ_of(1) !== OW'(1)) begin
            miscompares++;
            $display("[TB] FAIL col_counts: reject_cnt0=%0d occ0=%0d occ1=%0d expected 1 1 1",
                     rej_of(0), occ_of(0), occ_of(1));
        end
        sb_push(1, 32'd3, 8'h33);
        sb_push(0, 32'd7, 8'h77);
        serve_one(1'b0, "col_Y");
        serve_one(1'b0, "col_X");
    endtask

    task automatic test_back_to_back;
        do_reset();
        enqueue(0, 32'd10, 8'h10, 1'b1, "b2b_enq");
        wait_offer("b2b_offer");
        resp_valid  = 1'b1;
        resp_reject = 1'b0;
        in_valid    = 1'b1;
        in_type     = 2'd0;
        in_data     = make_data(0, 32'd4);
        in_slot     = 8'h04;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_accept_enq: in_ready=%b expected 1", in_ready);
        end
        tick();
        idle_inputs();
        vectors++;
        if (occ_of(0) !== OW'(1) || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_popush: occupancy0=%0d out_valid=%b expected 1 0", occ_of(0), out_valid);
        end
        sb_push(0, 32'd4, 8'h04);
        serve_one(1'b0, "b2b_serve");
    endtask

    task automatic test_reset_mid_offer;
        do_reset();
        enqueue(0, 32'd1, 8'hA0, 1'b1, "rmo_enq0");
        enqueue(1, 32'd2, 8'hA1, 1'b1, "rmo_enq1");
        enqueue(2, 32'd3, 8'hA2, 1'b1, "rmo_enq2");
        sb_push(0, 32'd1, 8'hA0);
        serve_one(1'b1, "rmo_reject");
        wait_offer("rmo_offer");
        rst      = 1'b1;
        in_valid = 1'b1;
        in_type  = 2'd3;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rmo_in_ready: in_ready=%b expected 0", in_ready);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        sb.delete();
        vectors++;
        if (out_valid !== 1'b0 || fifo_empty !== 1'b1 || lvt !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL rmo_flags: out_valid=%b fifo_empty=%b lvt=%h expected 0 1 ffffffff",
                     out_valid, fifo_empty, lvt);
        end
        vectors++;
        if (occupancy !== '0 || reject_cnt !== '0) begin
            miscompares++;
            $display("[TB] FAIL rmo_counts: occupancy=%h reject_cnt=%h expected 0 0", occupancy, reject_cnt);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rmo_stays_idle: out_valid=%b expected 0", out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        $display("[TB] starting multi_type_task_fifo bench");
        test_reset();
        test_latency();
        test_priority();
        test_reject();
        test_threshold();
        test_collision();
        test_back_to_back();
        test_reset_mid_offer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
